// File: rtl/salva_restaura_regs.sv
// Saves x1..x31 of a register file to a valid/ready stream or restores them from one.
// Save words appear two cycles after start at 1 word/cycle; either stream may stall indefinitely.
module salva_restaura_regs #(
  parameter int BITS = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  output logic            busy,
  output logic            done,
  output logic [4:0]      Ra,
  input  logic [BITS-1:0] douta,
  output logic [4:0]      Rw,
  output logic            We,
  output logic [BITS-1:0] din,
  output logic [BITS-1:0] out_data,
  output logic [4:0]      out_idx,
  output logic            out_valid,
  input  logic            out_ready,
  input  logic [BITS-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready
);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE, DONE} state_t;

  state_t          state_q, state_d;
  logic [5:0]      idx_q, idx_d;
  logic [BITS-1:0] out_data_q, out_data_d;
  logic [4:0]      out_idx_q, out_idx_d;
  logic            out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = mode ? RESTORE : SAVE;
          idx_d   = 6'd1;
        end
      end
      SAVE: begin
        // idx runs one ahead of out_idx, so the last word leaves with idx already at 32
        if (out_valid_q && out_ready && out_idx_q == 5'd31) begin
          out_valid_d = 1'b0;
          state_d     = DONE;
        end else if (idx_q <= 6'd31 && (!out_valid_q || out_ready)) begin
          out_data_d  = douta;
          out_idx_d   = idx_q[4:0];
          out_valid_d = 1'b1;
          idx_d       = idx_q + 6'd1;
        end
      end
      RESTORE: begin
        if (in_valid) begin
          idx_d = idx_q + 6'd1;
          if (idx_q == 6'd31) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 6'd0;
      out_data_q  <= '0;
      out_idx_q   <= 5'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = (state_q == SAVE) || (state_q == RESTORE);
  assign done      = (state_q == DONE);
  assign Ra        = (state_q == SAVE) ? idx_q[4:0] : 5'd0;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_valid = out_valid_q;
  // Reset gates the write port so an aborted restore commits nothing in the reset cycle
  assign in_ready  = (state_q == RESTORE) && !reset;
  assign We        = in_ready && in_valid;
  assign Rw        = We ? idx_q[4:0] : 5'd0;
  assign din       = We ? in_data : '0;

endmodule

// File: tb/tb_salva_restaura_regs.sv
// Randomised bench for salva_restaura_regs with a register-file model and a queue scoreboard.
module tb_salva_restaura_regs;
  localparam int BITS = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, mode, out_ready, in_valid;
  logic [BITS-1:0] in_data, douta, out_data, din;
  logic [4:0] Ra, Rw, out_idx;
  logic busy, done, We, out_valid, in_ready;

  salva_restaura_regs #(.BITS(BITS)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .done(done), .Ra(Ra), .douta(douta),
    .Rw(Rw), .We(We), .din(din),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );

  // Register file attached to the DUT ports
  logic [BITS-1:0] rf [32];
  assign douta = rf[Ra];
  always @(posedge clk) if (We) rf[Rw] <= din;

  typedef struct packed {
    logic [4:0]      idx;
    logic [BITS-1:0] dat;
  } beat_t;

  beat_t exp_save[$];
  beat_t exp_wr[$];
  logic [BITS-1:0] ref_rf [32];

  int compared = 0, mismatched = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int exp_done = 0, done_cnt = 0, t_start = 0, tmo_req = 0, tmo_seen = 0;
  bit timing_test = 0, final_req = 0, final_ack = 0, expect_idle = 0;

  task automatic chk(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endtask

  // Monitor: samples on the falling edge, checks against the scoreboard queues
  logic ov_prev = 0, stall_prev = 0, rst_prev = 0, done_prev = 0;
  logic [BITS-1:0] pd;
  logic [4:0] pi;
  always @(negedge clk) begin
    beat_t b;
    if (rst_prev) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_we", We, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_data", out_data, 0);
    end
    if (reset) begin
      chk("we_in_reset", We, 0);
      exp_save.delete();
      exp_wr.delete();
    end else begin
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_idx", out_idx, pi);
        chk("stall_data", out_data, pd);
      end
      if (out_valid && out_ready) begin
        if (exp_save.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL save_extra @cyc %0d: got word idx %0d, expected none", cyc, out_idx);
        end else begin
          b = exp_save.pop_front();
          chk("save_idx", out_idx, b.idx);
          chk("save_data", out_data, b.dat);
        end
      end
      if (We) begin
        chk("wr_not_x0", (Rw == 5'd0), 0);
        if (exp_wr.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL wr_extra @cyc %0d: got write Rw %0d, expected none", cyc, Rw);
        end else begin
          b = exp_wr.pop_front();
          chk("wr_rw", Rw, b.idx);
          chk("wr_din", din, b.dat);
        end
      end
      if (in_ready && !in_valid) chk("we_gap", We, 0);
      if (timing_test && out_valid && !ov_prev) chk("first_valid_cycle", cyc - t_start, 2);
      if (done) begin
        done_cnt++;
        chk("done_busy", busy, 0);
        if (timing_test) chk("done_cycle", cyc - t_start, 33);
      end
      if (done_prev) chk("done_one_cycle", done, 0);
      if (expect_idle) chk("idle_busy", busy, 0);
    end
    if (tmo_req != tmo_seen) begin
      tmo_seen = tmo_req;
      compared++; mismatched++;
      $display("FAIL timeout @cyc %0d: got no done, expected done within budget", cyc);
    end
    if (final_req && !final_ack) begin
      chk("done_count", done_cnt, exp_done);
      chk("queues_left", exp_save.size() + exp_wr.size(), 0);
      for (int k = 1; k < 32; k++) chk($sformatf("rf_x%0d", k), rf[k], ref_rf[k]);
      final_ack = 1;
    end
    stall_prev = out_valid && !out_ready && !reset;
    pd = out_data;
    pi = out_idx;
    ov_prev = out_valid;
    rst_prev = reset;
    done_prev = done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // dsel: 0 = k*0x1111, 1 = 0xA0+k, 2 = random; vmode: 0 = always valid, 1 = toggling, 2 = random
  task automatic restore_run(input int dsel, input int vmode, input int abort_after, input bit poke);
    int k = 1;
    int n = 0;
    bit v;
    logic [BITS-1:0] d;
    start = 1; mode = 1;
    step();
    start = 0;
    while (k <= 31) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (n % 2 == 0) : 1'($urandom_range(0, 1));
      d = (dsel == 0) ? 64'(k) * 64'h1111 : (dsel == 1) ? 64'hA0 + 64'(k) : {$urandom, $urandom};
      if (abort_after > 0 && k == abort_after + 1) begin
        in_valid = 1; in_data = d; reset = 1;
        step();
        reset = 0; in_valid = 0;
        step();
        return;
      end
      start = poke && (n == 5);
      mode  = 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = d;
      if (v) begin
        exp_wr.push_back('{idx: 5'(k), dat: d});
        ref_rf[k] = d;
        k++;
      end
      step();
      n++;
    end
    in_valid = 0; start = 0;
    exp_done++;
    repeat (3) step();
  endtask

  task automatic save_run(input int stall_at, input bit rnd, input int abort_at, input bit timed, input bit poke);
    int budget = 0;
    bit stalled = 0;
    for (int k = 1; k <= 31; k++) exp_save.push_back('{idx: 5'(k), dat: ref_rf[k]});
    out_ready = 1;
    start = 1; mode = 0;
    if (timed) begin
      t_start = cyc;
      timing_test = 1;
    end
    step();
    start = 0;
    while (!done && budget < 400) begin
      if (abort_at > 0 && out_valid && out_idx == 5'(abort_at)) begin
        reset = 1;
        step();
        reset = 0;
        step();
        return;
      end
      if (stall_at > 0 && !stalled && out_valid && out_idx == 5'(stall_at)) begin
        out_ready = 0;
        repeat (5) step();
        stalled = 1;
        budget += 5;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = poke && (budget == 8);
      mode = 1;
      step();
      budget++;
    end
    if (!done) tmo_req++;
    else exp_done++;
    start = 0; out_ready = 1;
    repeat (2) step();
    timing_test = 0;
  endtask

  initial begin
    reset = 1; start = 0; mode = 0; out_ready = 1; in_valid = 0; in_data = '0;
    for (int k = 0; k < 32; k++) ref_rf[k] = '0;
    repeat (3) step();
    reset = 0;
    step();

    restore_run(0, 0, 0, 0);
    save_run(0, 0, 0, 1, 0);
    restore_run(1, 0, 0, 1);
    save_run(7, 0, 0, 0, 0);
    restore_run(2, 1, 0, 0);
    save_run(0, 1, 0, 0, 1);
    restore_run(2, 2, 0, 0);
    save_run(0, 1, 0, 0, 0);
    save_run(0, 0, 12, 0, 0);
    restore_run(2, 0, 10, 0);
    save_run(0, 1, 0, 0, 0);

    reset = 1; start = 1; mode = 0;
    step();
    reset = 0; start = 0;
    expect_idle = 1;
    repeat (3) step();
    expect_idle = 0;

    final_req = 1;
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
